// File: rtl/alu_issue_ctrl.sv
// Sequential issue controller for the combinational ALU: request/response handshakes,
// architectural NZCV flag register, conditional commit. Optional macro: ALU_COND_EVAL_EN.
module alu_issue_ctrl #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [5:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic [3:0]   req_cond,
  input  logic         req_setflags,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [5:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_exec,
  output logic         rsp_illegal,
  output logic [3:0]   flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state;
  logic [3:0] cond_q;
  logic       setflags_q;
  logic       legal;
  logic       pass;
  logic       exec;
  logic [3:0] alu_flags;

  assign req_ready = (state == IDLE) && !rst;
  assign legal     = (alu_control == 6'b000000) || (alu_control == 6'b000001);
  assign exec      = legal && pass;
  assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

`ifdef ALU_COND_EVAL_EN
  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = flags;

  // Condition is evaluated against the flag register as it stood before this op.
  always_comb begin
    pass = 1'b0;
    unique case (cond_q)
      4'h0: pass = fz;
      4'h1: pass = !fz;
      4'h2: pass = fc;
      4'h3: pass = !fc;
      4'h4: pass = fn;
      4'h5: pass = !fn;
      4'h6: pass = fv;
      4'h7: pass = !fv;
      4'h8: pass = fc && !fz;
      4'h9: pass = !fc || fz;
      4'hA: pass = (fn == fv);
      4'hB: pass = (fn != fv);
      4'hC: pass = !fz && (fn == fv);
      4'hD: pass = fz || (fn != fv);
      4'hE: pass = 1'b1;
      4'hF: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^cond_q;
  assign pass        = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flags       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      cond_q      <= '0;
      setflags_q  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_exec    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a       <= req_a;
            alu_b       <= req_b;
            alu_control <= req_op;
            cond_q      <= req_cond;
            setflags_q  <= req_setflags;
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid   <= 1'b1;
          rsp_exec    <= exec;
          rsp_illegal <= !legal;
          rsp_result  <= exec ? alu_result : '0;
          // ALU flags only reach the register (and the response) on a committed op.
          if (exec && setflags_q) begin
            flags     <= alu_flags;
            rsp_flags <= alu_flags;
          end else begin
            rsp_flags <= flags;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural add/sub ALU attached.
module tb_alu_issue_ctrl;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [5:0]   req_op;
  logic [N-1:0] req_a, req_b;
  logic [3:0]   req_cond;
  logic         req_setflags;
  logic [N-1:0] alu_a, alu_b;
  logic [5:0]   alu_control;
  logic [N-1:0] alu_result;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_exec;
  logic         rsp_illegal;
  logic [3:0]   flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cond(req_cond), .req_setflags(req_setflags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_exec(rsp_exec), .rsp_illegal(rsp_illegal),
    .flags(flags)
  );

  // Reference ALU: add/sub with ARM-style carry; any other code returns junk with all flags set.
  logic [N:0] sum;
  always_comb begin
    sum = '0;
    alu_result = '0;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
    case (alu_control)
      6'b000000: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum[N-1:0];
        alu_v = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
        alu_c = sum[N];
        alu_n = alu_result[N-1];
        alu_z = (alu_result == '0);
      end
      6'b000001: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result = sum[N-1:0];
        alu_v = (alu_a[N-1] != alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
        alu_c = sum[N];
        alu_n = alu_result[N-1];
        alu_z = (alu_result == '0);
      end
      default: begin
        alu_result = 32'hDEADBEEF;
        {alu_n, alu_z, alu_c, alu_v} = 4'b1111;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE; returns after the capture edge with the response pending.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] op, input logic [3:0] cond, input logic sf);
    req_a = a; req_b = b; req_op = op; req_cond = cond; req_setflags = sf;
    req_valid = 1'b1;
    chk({tag, ".req_ready"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    chk({tag, ".exec_rsp_valid"}, rsp_valid, 0);
    chk({tag, ".alu_control"}, alu_control, op);
    step();
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, ".hs_rsp_valid"}, rsp_valid, 0);
    chk({tag, ".hs_req_ready"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_cond = '0; req_setflags = 1'b0;
    step(); step();
    chk("rst.req_ready", req_ready, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.flags", flags, 0);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.rsp_result", rsp_result, 0);
    rst = 1'b0;
    #1;
    chk("rst.req_ready_after", req_ready, 1);

    // 5 + 7
    issue("add57", 32'd5, 32'd7, 6'b000000, 4'hE, 1'b1);
    chk("add57.result", rsp_result, 32'd12);
    chk("add57.exec", rsp_exec, 1);
    chk("add57.illegal", rsp_illegal, 0);
    chk("add57.flags", flags, 4'b0000);
    handshake("add57");

    // carry-out to zero
    issue("addwrap", 32'hFFFFFFFF, 32'd1, 6'b000000, 4'hE, 1'b1);
    chk("addwrap.result", rsp_result, 32'd0);
    chk("addwrap.flags", flags, 4'b0110);
    chk("addwrap.rsp_flags", rsp_flags, 4'b0110);
    handshake("addwrap");

    issue("sub33", 32'd3, 32'd3, 6'b000001, 4'hE, 1'b0);
    chk("sub33.result", rsp_result, 32'd0);
    chk("sub33.exec", rsp_exec, 1);
    chk("sub33.flags", flags, 4'b0110);
    handshake("sub33");

    // setflags=0 with distinct ALU flags (N,V would be set)
    issue("addovf_nosf", 32'h7FFFFFFF, 32'd1, 6'b000000, 4'hE, 1'b0);
    chk("addovf_nosf.result", rsp_result, 32'h80000000);
    chk("addovf_nosf.flags", flags, 4'b0110);
    chk("addovf_nosf.rsp_flags", rsp_flags, 4'b0110);
    handshake("addovf_nosf");

    // NE with Z=1
    issue("ne", 32'd1, 32'd1, 6'b000000, 4'h1, 1'b1);
`ifdef ALU_COND_EVAL_EN
    chk("ne.exec", rsp_exec, 0);
    chk("ne.result", rsp_result, 0);
    chk("ne.flags", flags, 4'b0110);
`else
    chk("ne.exec", rsp_exec, 1);
    chk("ne.result", rsp_result, 32'd2);
    chk("ne.flags", flags, 4'b0000);
`endif
    handshake("ne");

`ifdef ALU_COND_EVAL_EN
    issue("eq", 32'd1, 32'd1, 6'b000000, 4'h0, 1'b1);
`else
    issue("eq", 32'd1, 32'd1, 6'b000000, 4'h1, 1'b1);
`endif
    chk("eq.exec", rsp_exec, 1);
    chk("eq.result", rsp_result, 32'd2);
    chk("eq.flags", flags, 4'b0000);
    handshake("eq");

    issue("never", 32'd2, 32'd2, 6'b000000, 4'hF, 1'b1);
`ifdef ALU_COND_EVAL_EN
    chk("never.exec", rsp_exec, 0);
    chk("never.result", rsp_result, 0);
`else
    chk("never.exec", rsp_exec, 1);
    chk("never.result", rsp_result, 32'd4);
`endif
    chk("never.flags", flags, 4'b0000);
    handshake("never");

    // illegal op: reference ALU would report 1111 if sampled
    issue("illegal", 32'd9, 32'd4, 6'b000101, 4'hE, 1'b1);
    chk("illegal.illegal", rsp_illegal, 1);
    chk("illegal.exec", rsp_exec, 0);
    chk("illegal.result", rsp_result, 0);
    chk("illegal.flags", flags, 4'b0000);
    chk("illegal.rsp_flags", rsp_flags, 4'b0000);
    handshake("illegal");

    // backpressure with a new request waiting
    issue("bp", 32'd10, 32'd20, 6'b000000, 4'hE, 1'b0);
    req_a = 32'd100; req_b = 32'd200; req_op = 6'b000000; req_cond = 4'hE; req_setflags = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.hold_valid", rsp_valid, 1);
      chk("bp.hold_result", rsp_result, 32'd30);
      chk("bp.hold_req_ready", req_ready, 0);
      chk("bp.hold_alu_a", alu_a, 32'd10);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp.idle_rsp_valid", rsp_valid, 0);
    chk("bp.idle_req_ready", req_ready, 1);
    chk("bp.idle_alu_a", alu_a, 32'd10);
    step();
    req_valid = 1'b0;
    chk("bp.accept_alu_a", alu_a, 32'd100);
    chk("bp.accept_req_ready", req_ready, 0);
    step();
    chk("bp.second_valid", rsp_valid, 1);
    chk("bp.second_result", rsp_result, 32'd300);
    handshake("bp2");

    // reset during EXEC after making flags non-zero
    issue("pre_rst", 32'hFFFFFFFF, 32'd1, 6'b000000, 4'hE, 1'b1);
    chk("pre_rst.flags", flags, 4'b0110);
    handshake("pre_rst");
    req_a = 32'd8; req_b = 32'd8; req_op = 6'b000001; req_cond = 4'hE; req_setflags = 1'b1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_exec.rsp_valid", rsp_valid, 0);
    chk("rst_exec.flags", flags, 4'b0000);
    chk("rst_exec.req_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_exec.req_ready", req_ready, 1);
    step();
    chk("rst_exec.no_rsp", rsp_valid, 0);
    chk("rst_exec.flags_after", flags, 4'b0000);

    issue("post_rst", 32'd5, 32'd7, 6'b000000, 4'hE, 1'b1);
    chk("post_rst.result", rsp_result, 32'd12);
    chk("post_rst.exec", rsp_exec, 1);
    handshake("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
